// File: rtl/mouse_disp_accum.sv
// -----------------------------------------------------------------------------
// mouse_disp_accum
//
// Takes the byte stream from a PS/2 byte receiver and turns it into the ball's
// per-frame motion inputs.
//
// Processing chain:
//   - A parser rebuilds the 3-byte PS/2 mouse packets from the byte stream.
//   - X/Y movement is summed between frames in saturating signed accumulators.
//   - Once per frame (a rising edge of frame_clk, synchronised into Clk) the
//     sums are clamped to +/-MAX_STEP and presented on xdisp/ydisp.
//   - The accumulators then restart from zero.
//
// Optional feature (compile-time macro MOUSE_OVERFLOW_CHECK_EN):
//   defined   : a packet whose X or Y overflow flag is set is discarded and
//               pkt_err pulses on its completion cycle.
//   undefined : the overflow flags are ignored.
//
// Parameters:
//   ACC_W       width of the signed X/Y accumulators (>= 10)
//   MAX_STEP    per-frame output magnitude clamp (<= 127)
//   TIMEOUT_CYC Clk cycles without a byte mid-packet before resync
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   frame_clk  in   frame-rate clock, asynchronous to Clk
//   rx_valid   in   one-cycle strobe, rx_data holds a received byte
//   rx_data    in   [7:0] received PS/2 byte
//   xdisp      out  [7:0] signed X displacement per frame (+ = right)
//   ydisp      out  [7:0] signed Y displacement per frame (+ = down)
//   buttons    out  [2:0] {middle, right, left} of last accepted packet
//   disp_valid out  one-cycle pulse when xdisp/ydisp update
//   pkt_err    out  one-cycle pulse on sync error, timeout or dropped packet
//   dbg_state  out  [1:0] parser state (0 WAIT_B0, 1 WAIT_B1, 2 WAIT_B2)
//
// Handshake:
//   rx_valid is a strobe with no back-pressure: every cycle it is high, one
//   byte is consumed. disp_valid is likewise a strobe with no ready;
//   xdisp/ydisp stay stable until the next strobe.
// -----------------------------------------------------------------------------
module mouse_disp_accum #(
  parameter int ACC_W       = 12,
  parameter int MAX_STEP    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] xdisp,
  output logic [7:0] ydisp,
  output logic [2:0] buttons,
  output logic       disp_valid,
  output logic       pkt_err,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] P_TIMEOUT = CNT_W'(TIMEOUT_CYC);

  localparam logic signed [ACC_W-1:0] P_POS_STEP = ACC_W'(MAX_STEP);
  localparam logic signed [ACC_W-1:0] P_NEG_STEP = -P_POS_STEP;
  localparam logic signed [ACC_W-1:0] P_ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] P_ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } parse_state_t;

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  parse_state_t r_state;
  parse_state_t w_state_next;

  logic [CNT_W-1:0] r_cnt;

  // Only the fields of byte 0 that are used later are kept.
  logic [2:0] r_b0_btn;
  logic       r_b0_xs;
  logic       r_b0_ys;
  logic [7:0] r_b1;

  logic signed [ACC_W-1:0] r_acc_x;
  logic signed [ACC_W-1:0] r_acc_y;

  logic r_fc_s1;
  logic r_fc_s2;
  logic r_fc_s3;

  logic r_pkt_err;
  logic r_disp_valid;
  logic [7:0] r_xdisp;
  logic [7:0] r_ydisp;
  logic [2:0] r_buttons;

  // ---------------------------------------------------------------------------
  // FSM control signals
  // ---------------------------------------------------------------------------
  logic w_load_b0;
  logic w_load_b1;
  logic w_pkt_done;
  logic w_sync_err;
  logic w_timeout;
  logic w_ovf_drop;
  logic w_pkt_accept;
  logic w_tick;

  logic signed [ACC_W-1:0] w_dx;
  logic signed [ACC_W-1:0] w_dy;
  logic signed [ACC_W-1:0] w_dy_neg;
  logic signed [ACC_W-1:0] w_sum_x;
  logic signed [ACC_W-1:0] w_sum_y;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Add one guard bit, then saturate instead of wrapping.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      return s[ACC_W] ? P_ACC_MIN : P_ACC_MAX;
    end
    return s[ACC_W-1:0];
  endfunction

  // Limit an accumulator value to +/-MAX_STEP and narrow it to the 8-bit port.
  function automatic logic [7:0] clamp_step(input logic signed [ACC_W-1:0] a);
    if (a > P_POS_STEP) begin
      return P_POS_STEP[7:0];
    end
    if (a < P_NEG_STEP) begin
      return P_NEG_STEP[7:0];
    end
    return a[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Parser FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= WAIT_B0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Parser FSM: next state and control
  // ---------------------------------------------------------------------------
  // A byte arriving on the same cycle the counter expires takes priority: it
  // is proof that the stream is still alive.
  always_comb begin
    w_state_next = r_state;
    w_load_b0    = 1'b0;
    w_load_b1    = 1'b0;
    w_pkt_done   = 1'b0;
    w_sync_err   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      WAIT_B0: begin
        if (rx_valid) begin
          // Bit 3 of the first byte is always 1 in a PS/2 mouse packet.
          if (rx_data[3]) begin
            w_load_b0    = 1'b1;
            w_state_next = WAIT_B1;
          end else begin
            w_sync_err   = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (rx_valid) begin
          w_load_b1    = 1'b1;
          w_state_next = WAIT_B2;
        end else if (r_cnt == P_TIMEOUT) begin
          w_timeout    = 1'b1;
          w_state_next = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (rx_valid) begin
          w_pkt_done   = 1'b1;
          w_state_next = WAIT_B0;
        end else if (r_cnt == P_TIMEOUT) begin
          w_timeout    = 1'b1;
          w_state_next = WAIT_B0;
        end
      end
      default: begin
        w_state_next = WAIT_B0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Inter-byte timeout counter
  // ---------------------------------------------------------------------------
  // Idle in WAIT_B0 is normal, so the counter only runs mid-packet.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (rx_valid || (r_state == WAIT_B0) || w_timeout) begin
      r_cnt <= '0;
    end else if (r_cnt != P_TIMEOUT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Packet byte capture
  // ---------------------------------------------------------------------------
  // Byte 2 is not stored: the packet completes on the cycle it arrives, so it
  // is decoded directly from rx_data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_b0_btn <= '0;
      r_b0_xs  <= 1'b0;
      r_b0_ys  <= 1'b0;
      r_b1     <= '0;
    end else begin
      if (w_load_b0) begin
        r_b0_btn <= rx_data[2:0];
        r_b0_xs  <= rx_data[4];
        r_b0_ys  <= rx_data[5];
      end
      if (w_load_b1) begin
        r_b1 <= rx_data;
      end
    end
  end

`ifdef MOUSE_OVERFLOW_CHECK_EN
  logic [1:0] r_b0_ovf;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_b0_ovf <= '0;
    end else if (w_load_b0) begin
      r_b0_ovf <= rx_data[7:6];
    end
  end

  assign w_ovf_drop = w_pkt_done & (|r_b0_ovf);
`else
  assign w_ovf_drop = 1'b0;
`endif

  assign w_pkt_accept = w_pkt_done & ~w_ovf_drop;

  // ---------------------------------------------------------------------------
  // Packet decode: 9-bit two's complement deltas
  // ---------------------------------------------------------------------------
  assign w_dx = {{(ACC_W-9){r_b0_xs}}, r_b0_xs, r_b1};
  assign w_dy = {{(ACC_W-9){r_b0_ys}}, r_b0_ys, rx_data};

  // PS/2 reports Y positive-up; the screen is positive-down.
  assign w_dy_neg = -w_dy;

  assign w_sum_x = sat_add(r_acc_x, w_dx);
  assign w_sum_y = sat_add(r_acc_y, w_dy_neg);

  // ---------------------------------------------------------------------------
  // frame_clk synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fc_s1 <= 1'b0;
      r_fc_s2 <= 1'b0;
      r_fc_s3 <= 1'b0;
    end else begin
      r_fc_s1 <= frame_clk;
      r_fc_s2 <= r_fc_s1;
      r_fc_s3 <= r_fc_s2;
    end
  end

  assign w_tick = r_fc_s2 & ~r_fc_s3;

  // ---------------------------------------------------------------------------
  // Accumulators
  // ---------------------------------------------------------------------------
  // On a tick the outputs take the pre-packet sums (below). A packet that
  // completes on the same cycle seeds the fresh frame, so no motion is lost.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_acc_x <= '0;
      r_acc_y <= '0;
    end else if (w_tick) begin
      r_acc_x <= w_pkt_accept ? w_dx     : '0;
      r_acc_y <= w_pkt_accept ? w_dy_neg : '0;
    end else if (w_pkt_accept) begin
      r_acc_x <= w_sum_x;
      r_acc_y <= w_sum_y;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_xdisp      <= '0;
      r_ydisp      <= '0;
      r_buttons    <= '0;
      r_disp_valid <= 1'b0;
      r_pkt_err    <= 1'b0;
    end else begin
      r_disp_valid <= w_tick;
      r_pkt_err    <= w_sync_err | w_timeout | w_ovf_drop;
      if (w_tick) begin
        r_xdisp <= clamp_step(r_acc_x);
        r_ydisp <= clamp_step(r_acc_y);
      end
      if (w_pkt_accept) begin
        r_buttons <= r_b0_btn;
      end
    end
  end

  assign xdisp      = r_xdisp;
  assign ydisp      = r_ydisp;
  assign buttons    = r_buttons;
  assign disp_valid = r_disp_valid;
  assign pkt_err    = r_pkt_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mouse_disp_accum.sv
// -----------------------------------------------------------------------------
// tb_mouse_disp_accum
//
// Directed testbench for mouse_disp_accum.
//   - Bytes are driven on the falling edge of Clk.
//   - DUT outputs are sampled on the falling edge of Clk.
//   - TIMEOUT_CYC is shortened so the timeout scenario runs quickly.
// -----------------------------------------------------------------------------
module tb_mouse_disp_accum;

  localparam int ACC_W       = 12;
  localparam int MAX_STEP    = 8;
  localparam int TIMEOUT_CYC = 64;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] xdisp;
  logic [7:0] ydisp;
  logic [2:0] buttons;
  logic       disp_valid;
  logic       pkt_err;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  mouse_disp_accum #(
    .ACC_W      (ACC_W),
    .MAX_STEP   (MAX_STEP),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .xdisp     (xdisp),
    .ydisp     (ydisp),
    .buttons   (buttons),
    .disp_valid(disp_valid),
    .pkt_err   (pkt_err),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Counts pkt_err pulses. Sampling at posedge sees the value from the
  // previous cycle, so readers wait one extra cycle after a pulse.
  always @(posedge Clk) begin
    if (pkt_err) err_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge Clk);
    @(negedge Clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  // Raises frame_clk and waits (bounded) for disp_valid.
  // lat counts Clk rising edges from the frame_clk rise; 0 means never seen.
  task automatic do_tick(output int lat);
    @(negedge Clk);
    frame_clk = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (disp_valid) begin
        lat = i;
        break;
      end
    end
    frame_clk = 1'b0;
    idle(4);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    Reset     = 1'b1;
    frame_clk = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    idle(3);
    checks++;
    if (xdisp !== 8'h00) begin
      errors++;
      $display("FAIL reset_xdisp: got %h expected 00", xdisp);
    end
    checks++;
    if (ydisp !== 8'h00) begin
      errors++;
      $display("FAIL reset_ydisp: got %h expected 00", ydisp);
    end
    checks++;
    if (buttons !== 3'b000) begin
      errors++;
      $display("FAIL reset_buttons: got %b expected 000", buttons);
    end
    checks++;
    if ({disp_valid, pkt_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00", {disp_valid, pkt_err});
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    Reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    int lat;
    send_pkt(8'h08, 8'h05, 8'h03);
    do_tick(lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL basic_tick_latency: got %0d expected 3", lat);
    end
    checks++;
    if (xdisp !== 8'h05) begin
      errors++;
      $display("FAIL basic_xdisp: got %h expected 05", xdisp);
    end
    checks++;
    if (ydisp !== 8'hFD) begin
      errors++;
      $display("FAIL basic_ydisp: got %h expected fd", ydisp);
    end
    checks++;
    if (buttons !== 3'b000) begin
      errors++;
      $display("FAIL basic_buttons: got %b expected 000", buttons);
    end
  endtask

  task automatic test_negative_clamp;
    int lat;
    send_pkt(8'h39, 8'hF0, 8'hFD);
    do_tick(lat);
    checks++;
    if (xdisp !== 8'hF8) begin
      errors++;
      $display("FAIL neg_xdisp: got %h expected f8", xdisp);
    end
    checks++;
    if (ydisp !== 8'h03) begin
      errors++;
      $display("FAIL neg_ydisp: got %h expected 03", ydisp);
    end
    checks++;
    if (buttons !== 3'b001) begin
      errors++;
      $display("FAIL neg_buttons: got %b expected 001", buttons);
    end
    do_tick(lat);
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL empty_tick_seen: got no disp_valid expected a pulse");
    end
    checks++;
    if ({xdisp, ydisp} !== 16'h0000) begin
      errors++;
      $display("FAIL empty_tick_disp: got %h expected 0000", {xdisp, ydisp});
    end
    checks++;
    if (buttons !== 3'b001) begin
      errors++;
      $display("FAIL empty_tick_buttons: got %b expected 001", buttons);
    end
  endtask

  task automatic test_sync_error;
    int lat;
    int e0;
    e0 = err_cnt;
    send_byte(8'h00);
    send_pkt(8'h08, 8'h02, 8'h00);
    idle(2);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL sync_err_pulses: got %0d expected 1", err_cnt - e0);
    end
    do_tick(lat);
    checks++;
    if (xdisp !== 8'h02) begin
      errors++;
      $display("FAIL sync_xdisp: got %h expected 02", xdisp);
    end
    checks++;
    if (ydisp !== 8'h00) begin
      errors++;
      $display("FAIL sync_ydisp: got %h expected 00", ydisp);
    end
  endtask

  task automatic test_timeout;
    int seen;
    send_byte(8'h08);
    send_byte(8'h07);
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL timeout_mid_state: got %0d expected 2", dbg_state);
    end
    seen = 0;
    for (int i = 1; i <= TIMEOUT_CYC + 10; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (pkt_err) begin
        seen = i;
        break;
      end
    end
    // Counter reaches TIMEOUT_CYC after that many idle edges; the next edge
    // fires the timeout.
    checks++;
    if (seen !== TIMEOUT_CYC + 1) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d expected %0d", seen, TIMEOUT_CYC + 1);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL timeout_state: got %0d expected 0", dbg_state);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_packet;
    int lat;
    send_byte(8'h08);
    send_byte(8'h01);
    @(negedge Clk);
    Reset = 1'b1;
    idle(2);
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_state: got %0d expected 0", dbg_state);
    end
    Reset = 1'b0;
    idle(1);
    send_pkt(8'h08, 8'h01, 8'h00);
    do_tick(lat);
    checks++;
    if (xdisp !== 8'h01) begin
      errors++;
      $display("FAIL midreset_xdisp: got %h expected 01", xdisp);
    end
    checks++;
    if (ydisp !== 8'h00) begin
      errors++;
      $display("FAIL midreset_ydisp: got %h expected 00", ydisp);
    end
  endtask

  task automatic test_simultaneous;
    int lat;
    send_pkt(8'h08, 8'h02, 8'h00);
    send_byte(8'h08);
    send_byte(8'h04);
    // Raise frame_clk so that the tick lands on the same edge as the last byte.
    frame_clk = 1'b1;
    idle(2);
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(posedge Clk);
    @(negedge Clk);
    rx_valid = 1'b0;
    checks++;
    if (disp_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_disp_valid: got %b expected 1", disp_valid);
    end
    checks++;
    if (xdisp !== 8'h02) begin
      errors++;
      $display("FAIL simul_first_xdisp: got %h expected 02", xdisp);
    end
    frame_clk = 1'b0;
    idle(4);
    do_tick(lat);
    checks++;
    if (xdisp !== 8'h04) begin
      errors++;
      $display("FAIL simul_second_xdisp: got %h expected 04", xdisp);
    end
  endtask

  task automatic test_overflow;
    int lat;
    int e0;
    e0 = err_cnt;
    send_pkt(8'h48, 8'h10, 8'h00);
    idle(2);
`ifdef MOUSE_OVERFLOW_CHECK_EN
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL ovf_err_pulses: got %0d expected 1", err_cnt - e0);
    end
    do_tick(lat);
    checks++;
    if (xdisp !== 8'h00) begin
      errors++;
      $display("FAIL ovf_xdisp: got %h expected 00", xdisp);
    end
`else
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL ovf_err_pulses: got %0d expected 0", err_cnt - e0);
    end
    do_tick(lat);
    checks++;
    if (xdisp !== 8'h08) begin
      errors++;
      $display("FAIL ovf_xdisp: got %h expected 08", xdisp);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_negative_clamp();
    test_sync_error();
    test_timeout();
    test_reset_mid_packet();
    test_simultaneous();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
